// File: rtl/cons_memory.sv
`default_nettype none
// ============================================================================
// Module   : cons_memory
// Purpose  : Single-port word memory serving evaluator cell fetch/store.
//            Clears itself with a one-word-per-cycle sweep after reset
//            (BUSY high), then accepts one-cycle REQ strobes.
//            Reads return through a READ_LATENCY-deep valid/data pipeline.
//            Optional feature macro: MEMORY_BOUNDS_CHECK_EN (out-of-range
//            requests flagged on ERR instead of aliasing modulo DEPTH).
// Revision : 1.0 - initial release
// ============================================================================
module cons_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic                  BUSY,
  output logic                  DATA_READY,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  ERR
);

  localparam int IDX_W = $clog2(DEPTH);

  // Reject parameter sets the storage and pipeline cannot represent.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEPTH > (1 << ADDR_WIDTH)) ||
      (READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_params
    $error("cons_memory: illegal DEPTH/ADDR_WIDTH/READ_LATENCY combination");
  end

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               busy_q;

  (* ram_style = "block" *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  logic [IDX_W-1:0] w_idx;
  logic             w_accept;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_sweep_we;
  logic             w_oor;

  assign w_idx      = ADDR_IN[IDX_W-1:0];
  // Reset always wins over a coincident request.
  assign w_accept   = REQ & ~busy_q & ~RST;
  assign w_wr_acc   = w_accept & WE;
  assign w_rd_acc   = w_accept & ~WE;
  assign w_sweep_we = (state_q == S_INIT) & ~RST;

`ifdef MEMORY_BOUNDS_CHECK_EN
  // Any address at or beyond DEPTH is out of range; extra bit keeps the
  // compare correct when DEPTH equals 2**ADDR_WIDTH.
  assign w_oor = ({1'b0, ADDR_IN} >= (ADDR_WIDTH + 1)'(DEPTH));
`else
  // Without bounds checking the upper address bits simply alias.
  assign w_oor = 1'b0;
  if (IDX_W < ADDR_WIDTH) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^ADDR_IN[ADDR_WIDTH-1:IDX_W];
  end
`endif

  // Sweep controller: clear every word once after reset, then serve forever.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_INIT: begin
          ptr_q <= ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= S_INIT;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage write port: sweep zeros during init, accepted in-range writes after.
  always_ff @(posedge CLK) begin
    if (w_sweep_we) begin
      mem_q[ptr_q] <= '0;
    end else if (w_wr_acc && !w_oor) begin
      mem_q[w_idx] <= DATA_IN;
    end
  end

  // Read pipeline: stage 0 is the RAM read register, later stages only move
  // data when a valid word passes, so DATA_OUT holds between pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= w_rd_acc;
      if (w_rd_acc) begin
        dat_q[0] <= w_oor ? '0 : mem_q[w_idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign BUSY       = busy_q;
  assign DATA_READY = vld_q[READ_LATENCY-1];
  assign DATA_OUT   = dat_q[READ_LATENCY-1];

`ifdef MEMORY_BOUNDS_CHECK_EN
  logic [READ_LATENCY-1:0] oor_q;
  logic                    wr_err_q;

  // Error tracking: write errors flag immediately, read errors travel with
  // their read so ERR lines up with DATA_READY.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oor_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= w_wr_acc & w_oor;
      oor_q[0] <= w_rd_acc & w_oor;
      for (int i = 1; i < READ_LATENCY; i++) begin
        oor_q[i] <= oor_q[i-1];
      end
    end
  end

  assign ERR = wr_err_q | (vld_q[READ_LATENCY-1] & oor_q[READ_LATENCY-1]);
`else
  assign ERR = 1'b0;
`endif

endmodule
`default_nettype wire
